// File: rtl/uart_pkg.sv
// UART shared definitions: frame state encoding (also used by the transmitter)
// and default frame geometry.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Even parity check: data is zero-extended, which leaves the XOR unchanged.
    function automatic logic parity_mismatch(
        input logic [8:0] data,
        input logic       par
    );
        return ^{data, par};
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial input.
// Both stages reset to 1 so an idle line produces no spurious edge.
module uart_sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit glitch reject, LSB-first data, stop check.
// Define UART_PARITY_EN to add an even-parity bit after the data bits.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic                  BCLK,
    input  logic                  reset_n,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_dout,
    output logic                  rx_done_tk,
    output logic                  frame_err,
    output logic                  parity_err,
    output logic                  rx_busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] C_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] C_FULL = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] C_LAST = BW'(DATA_WIDTH - 1);

`ifdef UART_PARITY_EN
    localparam uart_state_t AFTER_DATA = PARITY;
`else
    localparam uart_state_t AFTER_DATA = STOP;
`endif

    uart_state_t           r_state;
    uart_state_t           w_next;
    logic                  w_rx_s;
    logic                  r_rx_prev;
    logic                  w_fall;
    logic [CW-1:0]         r_cnt;
    logic [BW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_done;
    logic                  r_ferr;
    logic                  w_start_smp;
    logic                  w_data_smp;
    logic                  w_par_smp;
    logic                  w_stop_smp;
    logic                  w_last_bit;

    uart_sync2 u_sync (
        .i_clk   (BCLK),
        .i_rst_n (reset_n),
        .i_d     (rx),
        .o_q     (w_rx_s)
    );

    // Edge rather than level, so a line stuck low cannot restart a frame.
    assign w_fall = r_rx_prev & ~w_rx_s;

    always_ff @(posedge BCLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_next = START;
                end
            end
            START: begin
                if (w_start_smp) begin
                    w_next = w_rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_data_smp && w_last_bit) begin
                    w_next = AFTER_DATA;
                end
            end
            PARITY: begin
                if (w_par_smp) begin
                    w_next = STOP;
                end
            end
            STOP: begin
                if (w_stop_smp) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_comb begin
        w_start_smp = (r_state == START)  && (r_cnt == C_HALF);
        w_data_smp  = (r_state == DATA)   && (r_cnt == C_FULL);
        w_par_smp   = (r_state == PARITY) && (r_cnt == C_FULL);
        w_stop_smp  = (r_state == STOP)   && (r_cnt == C_FULL);
        w_last_bit  = (r_bit_cnt == C_LAST);
        rx_busy     = (r_state != IDLE);
    end

    always_ff @(posedge BCLK or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_prev <= 1'b1;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_dout    <= '0;
            r_done    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_rx_prev <= w_rx_s;

            if ((r_state != w_next) || (r_state == IDLE)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end

            if (r_state != DATA) begin
                r_bit_cnt <= '0;
            end else if (w_data_smp) begin
                r_bit_cnt <= r_bit_cnt + BW'(1);
            end

            if (w_data_smp) begin
                r_shift <= {w_rx_s, r_shift[DATA_WIDTH-1:1]};
            end

            // Data is delivered even with a bad stop bit; frame_err flags it.
            r_done <= w_stop_smp;
            if (w_stop_smp) begin
                r_dout <= r_shift;
                r_ferr <= ~w_rx_s;
            end
        end
    end

`ifdef UART_PARITY_EN
    logic r_par_bit;
    logic r_perr;

    always_ff @(posedge BCLK or negedge reset_n) begin
        if (!reset_n) begin
            r_par_bit <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            if (w_par_smp) begin
                r_par_bit <= w_rx_s;
            end
            if (w_stop_smp) begin
                r_perr <= parity_mismatch(9'(r_shift), r_par_bit);
            end
        end
    end

    assign parity_err = r_perr;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_dout    = r_dout;
    assign rx_done_tk = r_done;
    assign frame_err  = r_ferr;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand-written
// sequences for back-to-back, glitch, stuck-low stop and mid-frame reset.
module tb_uart_rx;

    localparam int OS = 16;
    localparam int DW = 8;
`ifdef UART_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic          BCLK = 1'b0;
    logic          reset_n = 1'b0;
    logic          rx = 1'b1;
    logic [DW-1:0] rx_dout;
    logic          rx_done_tk;
    logic          frame_err;
    logic          parity_err;
    logic          rx_busy;

    uart_rx #(
        .OVERSAMPLE (OS),
        .DATA_WIDTH (DW)
    ) dut (
        .BCLK       (BCLK),
        .reset_n    (reset_n),
        .rx         (rx),
        .rx_dout    (rx_dout),
        .rx_done_tk (rx_done_tk),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .rx_busy    (rx_busy)
    );

    always #5 BCLK = ~BCLK;

    typedef struct {
        logic [DW-1:0] data;
        logic          stop;
        logic          par;
        logic [DW-1:0] exp_dout;
        logic          exp_ferr;
        logic          exp_perr;
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;
    int   wide_cnt = 0;
    logic done_q = 1'b0;

    always @(posedge BCLK) begin
        if (rx_done_tk) done_cnt <= done_cnt + 1;
        if (rx_done_tk && done_q) wide_cnt <= wide_cnt + 1;
        done_q <= rx_done_tk;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (OS) @(negedge BCLK);
    endtask

    task automatic send_head(input logic [DW-1:0] d, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < DW; i++) send_bit(d[i]);
        if (PAR_EN) send_bit(par);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic stop,
                              input logic par);
        send_head(d, par);
        send_bit(stop);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge BCLK);
    endtask

    vec_t vecs[$];
    int   base;
    int   lat;
    logic [DW-1:0] held;

    initial begin
        vecs.push_back('{8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0});
        vecs.push_back('{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0});
        vecs.push_back('{8'h80, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0});
        vecs.push_back('{8'h5A, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0});
        vecs.push_back('{8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0});
        vecs.push_back('{8'h07, 1'b1, 1'b0, 8'h07, 1'b0, PAR_EN});

        repeat (3) @(negedge BCLK);
        check("rst_dout", 32'(rx_dout), 32'h0);
        check("rst_done", 32'(rx_done_tk), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_perr", 32'(parity_err), 32'h0);
        check("rst_busy", 32'(rx_busy), 32'h0);
        reset_n = 1'b1;
        idle(10);

        // 0xA5 with stop-sample latency: 2 sync + 1 edge + 152 + observe.
        base = done_cnt;
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                while (!rx_done_tk && lat < 400) begin
                    @(negedge BCLK);
                    lat++;
                end
            end
        join
        idle(20);
        check("a5_latency", 32'(lat), 32'(3 + OS / 2 + (DW + 1 + PAR_EN) * OS));
        check("a5_dout", 32'(rx_dout), 32'hA5);
        check("a5_ferr", 32'(frame_err), 32'h0);
        check("a5_done", 32'(done_cnt - base), 32'd1);
        check("a5_busy", 32'(rx_busy), 32'h0);

        foreach (vecs[i]) begin
            base = done_cnt;
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].par);
            idle(20);
            check($sformatf("v%0d_dout", i), 32'(rx_dout), 32'(vecs[i].exp_dout));
            check($sformatf("v%0d_ferr", i), 32'(frame_err), 32'(vecs[i].exp_ferr));
            check($sformatf("v%0d_perr", i), 32'(parity_err), 32'(vecs[i].exp_perr));
            check($sformatf("v%0d_done", i), 32'(done_cnt - base), 32'd1);
            check($sformatf("v%0d_busy", i), 32'(rx_busy), 32'h0);
        end

        // Back-to-back frames with no idle gap.
        base = done_cnt;
        send_frame(8'h3C, 1'b1, 1'b0);
        check("b2b_first", 32'(rx_dout), 32'h3C);
        send_frame(8'hC3, 1'b1, 1'b0);
        idle(20);
        check("b2b_second", 32'(rx_dout), 32'hC3);
        check("b2b_done", 32'(done_cnt - base), 32'd2);

        // Short low glitch is rejected at the start-bit midpoint.
        base = done_cnt;
        rx = 1'b0;
        repeat (4) @(negedge BCLK);
        rx = 1'b1;
        check("glitch_busy_hi", 32'(rx_busy), 32'h1);
        idle(40);
        check("glitch_busy_lo", 32'(rx_busy), 32'h0);
        check("glitch_done", 32'(done_cnt - base), 32'd0);
        check("glitch_dout", 32'(rx_dout), 32'hC3);

        // Stop bit low, line stuck low: one frame, no retrigger.
        base = done_cnt;
        send_head(8'h55, 1'b0);
        rx = 1'b0;
        repeat (40) @(negedge BCLK);
        check("ferr_dout", 32'(rx_dout), 32'h55);
        check("ferr_flag", 32'(frame_err), 32'h1);
        check("ferr_done", 32'(done_cnt - base), 32'd1);
        check("ferr_busy", 32'(rx_busy), 32'h0);
        idle(30);
        check("ferr_no_retrig", 32'(done_cnt - base), 32'd1);
        send_frame(8'h96, 1'b1, 1'b0);
        idle(20);
        check("ferr_next_dout", 32'(rx_dout), 32'h96);
        check("ferr_next_flag", 32'(frame_err), 32'h0);
        check("ferr_next_done", 32'(done_cnt - base), 32'd2);

        // Reset asserted mid bit 3 of 0xFF.
        base = done_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        rx = 1'b1;
        repeat (8) @(negedge BCLK);
        #2 reset_n = 1'b0;
        #1;
        check("mrst_dout", 32'(rx_dout), 32'h0);
        check("mrst_done", 32'(rx_done_tk), 32'h0);
        check("mrst_ferr", 32'(frame_err), 32'h0);
        check("mrst_perr", 32'(parity_err), 32'h0);
        check("mrst_busy", 32'(rx_busy), 32'h0);
        repeat (3) @(negedge BCLK);
        reset_n = 1'b1;
        idle(80);
        check("mrst_idle_done", 32'(done_cnt - base), 32'd0);
        check("mrst_idle_busy", 32'(rx_busy), 32'h0);
        send_frame(8'h81, 1'b1, 1'b0);
        idle(20);
        check("mrst_81_dout", 32'(rx_dout), 32'h81);
        check("mrst_81_ferr", 32'(frame_err), 32'h0);
        check("mrst_81_done", 32'(done_cnt - base), 32'd1);

        check("done_pulse_width", 32'(wide_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
